// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   XLEN             : address / instruction width
//   RESET_PC_DEFAULT : fetch PC after reset unless overridden by the top parameter
//   if_state_t       : fetch FSM encodings (IF_IDLE / IF_WAIT / IF_DROP)
//   fetch_entry_t    : buffered {pc, instr} payload held in the fetch queue
package instr_fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_WAIT = 2'd1,
    IF_DROP = 2'd2
  } if_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Clear the byte-offset bits of a redirect target.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_if_queue.sv
// Fetch buffer: DEPTH-entry FIFO of {pc, instr} words between memory and ID.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   push_i       : write entry_i at the tail (caller guarantees not full)
//   pop_i        : drop the head entry (caller guarantees not empty)
//   flush_i      : empty the queue; overrides push/pop
//   entry_i      : payload to push
//   head_o       : payload at the head (undefined content when empty)
//   count_o      : number of valid entries
//   empty_o      : count_o == 0
module instr_fetch_if_queue
  import instr_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  fetch_entry_t      entry_i,
  output fetch_entry_t      head_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              empty_o
);

  fetch_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;

  // Storage needs no reset: the head is only consumed when count is non-zero.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= entry_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the fetch PC, issues one-outstanding word
// reads, buffers returned words with their PCs and issues one per cycle to ID.
// Redirects flush the buffer and discard any read still in flight.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   rdy           : global enable, 0 freezes all state
//   mem_req/addr  : level read request and its word address (registered)
//   mem_valid/data: one-cycle read return for the outstanding request
//   id_stall      : ID cannot accept an instruction this cycle
//   jump_en/pc    : one-cycle redirect and its target
//   IF_valid      : instruction handed to ID this cycle
//   instruction   : head word (0 when buffer empty)
//   pc_out        : head PC (0 when buffer empty)
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  output logic             mem_req,
  output logic [XLEN-1:0]  mem_addr,
  input  logic             mem_valid,
  input  logic [XLEN-1:0]  mem_data,
  input  logic             id_stall,
  input  logic             jump_en,
  input  logic [XLEN-1:0]  jump_pc,
  output logic             IF_valid,
  output logic [XLEN-1:0]  instruction,
  output logic [XLEN-1:0]  pc_out
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  if_state_t        state_q, state_d;
  logic             mem_req_q, mem_req_d;
  logic [XLEN-1:0]  mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;

  logic             q_push, q_pop, q_flush, q_empty, has_room;
  logic [CNT_W-1:0] q_count;
  fetch_entry_t     q_head, q_entry;

  // Issue gating: a redirect or a frozen pipe never hands an instruction over.
  assign IF_valid = rdy & ~q_empty & ~id_stall & ~jump_en;
  assign q_pop    = IF_valid;
  assign q_flush  = rdy & jump_en;
  assign q_entry  = '{pc: fetch_pc_q, instr: mem_data};

  // Only request when the returned word is guaranteed a free slot.
  assign has_room = (q_count < CNT_W'(DEPTH));

  // Next-state logic for the fetch FSM and memory handshake.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fetch_pc_d = fetch_pc_q;
    q_push     = 1'b0;

    if (rdy) begin
      if (jump_en) begin
        fetch_pc_d = word_align(jump_pc);
      end

      case (state_q)
        IF_IDLE: begin
          if (has_room && !jump_en) begin
            mem_req_d  = 1'b1;
            mem_addr_d = fetch_pc_q;
            state_d    = IF_WAIT;
          end
        end
        IF_WAIT: begin
          if (mem_valid) begin
            mem_req_d = 1'b0;
            state_d   = IF_IDLE;
            // A redirect in the same cycle makes the returned word stale.
            if (!jump_en) begin
              q_push     = 1'b1;
              fetch_pc_d = fetch_pc_q + 32'd4;
            end
          end else if (jump_en) begin
            state_d = IF_DROP;
          end
        end
        IF_DROP: begin
          // Wait out the stale return; the request stays asserted until then.
          if (mem_valid) begin
            mem_req_d = 1'b0;
            state_d   = IF_IDLE;
          end
        end
        default: begin
          state_d   = IF_IDLE;
          mem_req_d = 1'b0;
        end
      endcase
    end
  end

  // Fetch FSM, handshake and PC registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IF_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instruction = q_empty ? '0 : q_head.instr;
  assign pc_out      = q_empty ? '0 : q_head.pc;

  instr_fetch_if_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (q_push),
    .pop_i   (q_pop),
    .flush_i (q_flush),
    .entry_i (q_entry),
    .head_o  (q_head),
    .count_o (q_count),
    .empty_o (q_empty)
  );

endmodule
